// File: rtl/wb_stage_p.sv
// -----------------------------------------------------------------------------
// wb_stage_p -- RV32I write-back stage
//
// Holds the MEM/WB pipeline entry. A load stays in write-back until its
// data-memory response arrives through a valid/ready handshake. While the
// response is outstanding, a busy request stalls the upstream stages.
// The load data is aligned, then sign- or zero-extended, and selected onto
// the register-file write port.
//
// Optional feature macro: WB_INSTRET_EN
//   defined   -> o_instret is a wrapping 64-bit retired-instruction counter
//   undefined -> no counter is built and o_instret is tied to zero
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   i_valid                memory stage presents an instruction
//   i_rd_addr, i_rd_wr     destination register and its write intent
//   i_ALUout               ALU result (used when the instruction is not a load)
//   i_DM_OE                instruction is a load
//   i_funct3, i_byte_off   load type and address[1:0]
//   stall, flush           global stall (no capture) / kill the held entry
//   i_DM_valid, i_DM_data  load response handshake and raw word
//   o_DM_ready             response accepted when high with i_DM_valid
//   o_rd_addr/data/wr      register-file write port
//   o_wb_busy              stall request while a response is outstanding
//   o_retire               one-cycle pulse per completed instruction
//   o_instret              retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage_p #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [RF_AW-1:0] i_rd_addr,
    input  logic [XLEN-1:0]  i_ALUout,
    input  logic             i_rd_wr,
    input  logic             i_DM_OE,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_byte_off,
    input  logic             stall,
    input  logic             flush,
    input  logic             i_DM_valid,
    input  logic [XLEN-1:0]  i_DM_data,
    output logic             o_DM_ready,
    output logic [RF_AW-1:0] o_rd_addr,
    output logic [XLEN-1:0]  o_rd_data,
    output logic             o_rd_wr,
    output logic             o_wb_busy,
    output logic             o_retire,
    output logic [63:0]      o_instret
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_VALID   = 2'd1,
        ST_WAIT_LD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [RF_AW-1:0]  rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic              rd_wr_q, rd_wr_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        byte_off_q, byte_off_d;
    logic [XLEN-1:0]   ld_data_q, ld_data_d;
    logic              retire_q, retire_d;
    logic              busy_s;
    logic              cap_s;

    // Aligns the addressed byte/halfword to bit 0 and extends it to XLEN.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        half_s = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  fmt_load = {{(XLEN-8){byte_s[7]}}, byte_s};
            3'b001:  fmt_load = {{(XLEN-16){half_s[15]}}, half_s};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, byte_s};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, half_s};
            // LW and undefined codes pass the word through unchanged
            default: fmt_load = word;
        endcase
    endfunction

    // Busy derives purely from the state register, so it cannot glitch.
    assign busy_s = (state_q == ST_WAIT_LD) || (state_q == ST_DRAIN);
    assign cap_s  = !stall && !busy_s && !flush;

    // Next-state logic: flush outranks capture; responses drain regardless of stall.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        alu_d      = alu_q;
        rd_wr_d    = rd_wr_q;
        is_load_d  = is_load_q;
        funct3_d   = funct3_q;
        byte_off_d = byte_off_q;
        ld_data_d  = ld_data_q;
        retire_d   = 1'b0;
        case (state_q)
            ST_EMPTY, ST_VALID: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (cap_s) begin
                    rd_addr_d  = i_rd_addr;
                    alu_d      = i_ALUout;
                    rd_wr_d    = i_rd_wr;
                    is_load_d  = i_DM_OE;
                    funct3_d   = i_funct3;
                    byte_off_d = i_byte_off;
                    if (!i_valid) begin
                        state_d = ST_EMPTY;
                    end else if (!i_DM_OE) begin
                        state_d  = ST_VALID;
                        retire_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LD;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_LD: begin
                if (i_DM_valid) begin
                    if (flush) begin
                        // response consumed but the instruction is dead
                        state_d = ST_EMPTY;
                    end else begin
                        ld_data_d = fmt_load(funct3_q, byte_off_q, i_DM_data);
                        state_d   = ST_VALID;
                        retire_d  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT_LD;
                end
            end
            ST_DRAIN: begin
                if (i_DM_valid) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Pipeline entry and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rd_addr_q  <= '0;
            alu_q      <= '0;
            rd_wr_q    <= 1'b0;
            is_load_q  <= 1'b0;
            funct3_q   <= 3'd0;
            byte_off_q <= 2'd0;
            ld_data_q  <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            alu_q      <= alu_d;
            rd_wr_q    <= rd_wr_d;
            is_load_q  <= is_load_d;
            funct3_q   <= funct3_d;
            byte_off_q <= byte_off_d;
            ld_data_q  <= ld_data_d;
            retire_q   <= retire_d;
        end
    end

    assign o_DM_ready = busy_s;
    assign o_wb_busy  = busy_s;
    assign o_rd_addr  = rd_addr_q;
    assign o_rd_data  = is_load_q ? ld_data_q : alu_q;
    assign o_rd_wr    = (state_q == ST_VALID) && rd_wr_q && (rd_addr_q != {RF_AW{1'b0}});
    assign o_retire   = retire_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Retired-instruction counter; wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (retire_q) begin
            instret_q <= instret_q + 64'd1;
        end else begin
            instret_q <= instret_q;
        end
    end

    assign o_instret = instret_q;
`else
    assign o_instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
module tb_wb_stage_p;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_ALUout;
    logic        i_rd_wr;
    logic        i_DM_OE;
    logic [2:0]  i_funct3;
    logic [1:0]  i_byte_off;
    logic        stall;
    logic        flush;
    logic        i_DM_valid;
    logic [31:0] i_DM_data;
    logic        o_DM_ready;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wr;
    logic        o_wb_busy;
    logic        o_retire;
    logic [63:0] o_instret;

    int          n_cmp;
    int          n_bad;
    logic [63:0] exp_ret;

    wb_stage_p #(.XLEN(32), .RF_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_rd_addr  (i_rd_addr),
        .i_ALUout   (i_ALUout),
        .i_rd_wr    (i_rd_wr),
        .i_DM_OE    (i_DM_OE),
        .i_funct3   (i_funct3),
        .i_byte_off (i_byte_off),
        .stall      (stall),
        .flush      (flush),
        .i_DM_valid (i_DM_valid),
        .i_DM_data  (i_DM_data),
        .o_DM_ready (o_DM_ready),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_wr    (o_rd_wr),
        .o_wb_busy  (o_wb_busy),
        .o_retire   (o_retire),
        .o_instret  (o_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_instret(input string tag);
`ifdef WB_INSTRET_EN
        chk(tag, o_instret, exp_ret);
`else
        chk(tag, o_instret, 64'd0);
`endif
    endtask

    task automatic present(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                           input logic wr, input logic ld, input logic [2:0] f3,
                           input logic [1:0] off);
        i_valid    = v;
        i_rd_addr  = rd;
        i_ALUout   = alu;
        i_rd_wr    = wr;
        i_DM_OE    = ld;
        i_funct3   = f3;
        i_byte_off = off;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_ret = 64'd0;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        i_DM_valid = 1'b0;
        i_DM_data = 32'd0;
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();
        tick();

        // reset state
        chk("rst_addr", {59'd0, o_rd_addr}, 64'd0);
        chk("rst_data", {32'd0, o_rd_data}, 64'd0);
        chk("rst_wr", {63'd0, o_rd_wr}, 64'd0);
        chk("rst_ready", {63'd0, o_DM_ready}, 64'd0);
        chk("rst_busy", {63'd0, o_wb_busy}, 64'd0);
        chk("rst_retire", {63'd0, o_retire}, 64'd0);
        chk("rst_instret", o_instret, 64'd0);
        rst = 1'b0;

        // non-load rd=5
        present(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        exp_ret = exp_ret + 64'd1;
        chk("alu_wr", {63'd0, o_rd_wr}, 64'd1);
        chk("alu_addr", {59'd0, o_rd_addr}, 64'd5);
        chk("alu_data", {32'd0, o_rd_data}, 64'h1234);
        chk("alu_retire", {63'd0, o_retire}, 64'd1);
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();
        chk("empty_wr", {63'd0, o_rd_wr}, 64'd0);
        chk("empty_retire", {63'd0, o_retire}, 64'd0);
        chk_instret("instret_1");

        // LB, byte_off=3, 3 wait cycles then handshake
        present(1'b1, 5'd6, 32'h0000_AAAA, 1'b1, 1'b1, 3'b000, 2'd3);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        chk("lb_busy_c1", {63'd0, o_wb_busy}, 64'd1);
        chk("lb_wr_c1", {63'd0, o_rd_wr}, 64'd0);
        chk("lb_retire_c1", {63'd0, o_retire}, 64'd0);
        tick();
        chk("lb_busy_c2", {63'd0, o_wb_busy}, 64'd1);
        tick();
        chk("lb_busy_c3", {63'd0, o_wb_busy}, 64'd1);
        tick();
        chk("lb_busy_hs", {63'd0, o_wb_busy}, 64'd1);
        chk("lb_ready_hs", {63'd0, o_DM_ready}, 64'd1);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'h80FF_FF7F;
        tick();
        i_DM_valid = 1'b0;
        exp_ret = exp_ret + 64'd1;
        chk("lb_data", {32'd0, o_rd_data}, 64'hFFFF_FF80);
        chk("lb_wr", {63'd0, o_rd_wr}, 64'd1);
        chk("lb_addr", {59'd0, o_rd_addr}, 64'd6);
        chk("lb_retire", {63'd0, o_retire}, 64'd1);
        chk("lb_busy_after", {63'd0, o_wb_busy}, 64'd0);

        // LBU captured straight from VALID, response in first wait cycle
        present(1'b1, 5'd6, 32'd0, 1'b1, 1'b1, 3'b100, 2'd3);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        chk("lbu_retire_wait", {63'd0, o_retire}, 64'd0);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'h80FF_FF7F;
        tick();
        i_DM_valid = 1'b0;
        exp_ret = exp_ret + 64'd1;
        chk("lbu_data", {32'd0, o_rd_data}, 64'h0000_0080);
        chk("lbu_wr", {63'd0, o_rd_wr}, 64'd1);

        // LH, byte_off=2
        present(1'b1, 5'd7, 32'd0, 1'b1, 1'b1, 3'b001, 2'd2);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'h9ABC_0000;
        tick();
        i_DM_valid = 1'b0;
        exp_ret = exp_ret + 64'd1;
        chk("lh_data", {32'd0, o_rd_data}, 64'hFFFF_9ABC);
        chk("lh_retire", {63'd0, o_retire}, 64'd1);

        // LHU, byte_off=2
        present(1'b1, 5'd7, 32'd0, 1'b1, 1'b1, 3'b101, 2'd2);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'h9ABC_0000;
        tick();
        i_DM_valid = 1'b0;
        exp_ret = exp_ret + 64'd1;
        chk("lhu_data", {32'd0, o_rd_data}, 64'h0000_9ABC);

        // LW passes the word unchanged
        present(1'b1, 5'd8, 32'd0, 1'b1, 1'b1, 3'b010, 2'd0);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'h1234_5678;
        tick();
        i_DM_valid = 1'b0;
        exp_ret = exp_ret + 64'd1;
        chk("lw_data", {32'd0, o_rd_data}, 64'h1234_5678);

        // rd=0: no write, still retires
        present(1'b1, 5'd0, 32'h0000_DEAD, 1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        exp_ret = exp_ret + 64'd1;
        chk("x0_wr", {63'd0, o_rd_wr}, 64'd0);
        chk("x0_retire", {63'd0, o_retire}, 64'd1);
        chk("x0_data", {32'd0, o_rd_data}, 64'h0000_DEAD);

        // flush in 2nd WAIT_LD cycle, response 2 cycles later
        present(1'b1, 5'd9, 32'd0, 1'b1, 1'b1, 3'b010, 2'd0);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_ready1", {63'd0, o_DM_ready}, 64'd1);
        chk("drain_busy1", {63'd0, o_wb_busy}, 64'd1);
        chk("drain_wr1", {63'd0, o_rd_wr}, 64'd0);
        tick();
        chk("drain_ready2", {63'd0, o_DM_ready}, 64'd1);
        i_DM_valid = 1'b1;
        i_DM_data  = 32'hCAFE_F00D;
        tick();
        i_DM_valid = 1'b0;
        chk("drain_busy_end", {63'd0, o_wb_busy}, 64'd0);
        chk("drain_ready_end", {63'd0, o_DM_ready}, 64'd0);
        chk("drain_wr_end", {63'd0, o_rd_wr}, 64'd0);
        chk("drain_retire_end", {63'd0, o_retire}, 64'd0);
        tick();
        chk("drain_retire_late", {63'd0, o_retire}, 64'd0);

        // flush beats capture
        present(1'b1, 5'd3, 32'h0000_0003, 1'b1, 1'b0, 3'd0, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        chk("flushcap_wr", {63'd0, o_rd_wr}, 64'd0);
        chk("flushcap_retire", {63'd0, o_retire}, 64'd0);

        // stall held 4 cycles on a VALID entry
        present(1'b1, 5'd9, 32'h0000_5555, 1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        exp_ret = exp_ret + 64'd1;
        chk("stall_first_retire", {63'd0, o_retire}, 64'd1);
        stall = 1'b1;
        present(1'b1, 5'd10, 32'h0000_AAAA, 1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_addr", {59'd0, o_rd_addr}, 64'd9);
            chk("stall_data", {32'd0, o_rd_data}, 64'h5555);
            chk("stall_wr", {63'd0, o_rd_wr}, 64'd1);
            chk("stall_retire", {63'd0, o_retire}, 64'd0);
            chk_instret("stall_instret");
        end
        stall = 1'b0;
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();

        // reset mid-load returns to EMPTY at once
        present(1'b1, 5'd4, 32'd0, 1'b1, 1'b1, 3'b010, 2'd0);
        tick();
        present(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        chk("pre_rst_busy", {63'd0, o_wb_busy}, 64'd1);
        rst = 1'b1;
        #1;
        exp_ret = 64'd0;
        chk("rst_mid_busy", {63'd0, o_wb_busy}, 64'd0);
        chk("rst_mid_addr", {59'd0, o_rd_addr}, 64'd0);
        chk("rst_mid_instret", o_instret, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
